scale_note_quantizer: RTL

//  Sequential successor to the single-mode scale snapper in the auto-tune pitch path.

---
 rtl/scale_note_quantizer_pkg.sv | 50 +++++
 rtl/scale_note_quantizer_if.sv | 34 +++
 rtl/scale_note_quantizer_note_freq_rom.sv | 47 ++++
 rtl/scale_note_quantizer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_note_quantizer_pkg.sv
// Shared definitions for the auto-tune scale quantizer: default widths,
// search-mode codes, FSM encoding and the octave-0 note frequency table.
package auto_tune_pkg;

    localparam int DEF_NOTES  = 12;
    localparam int DEF_OCT_W  = 3;
    localparam int DEF_FREQ_W = 32;
    localparam int DEF_FRAC_W = 16;

    // Precision the F0 table constants are written in.
    localparam int F0_FRAC_W  = 16;

    localparam logic [1:0] MODE_DOWN    = 2'd0;
    localparam logic [1:0] MODE_UP      = 2'd1;
    localparam logic [1:0] MODE_NEAREST = 2'd2;

    // ST_HIT replays a cached result without touching the search or the ROM.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_LOOKUP,
        ST_HIT,
        ST_DONE
    } state_e;

    typedef logic [DEF_FREQ_W-1:0] f0_t;

    // Octave-0 note frequencies in Q16.16 Hz (C0 = 16.3516 Hz).
    function automatic f0_t note_f0(input logic [3:0] n);
        f0_t r;
        r = '0;
        case (n)
            4'd0:    r = f0_t'(1071618);
            4'd1:    r = f0_t'(1135339);
            4'd2:    r = f0_t'(1202848);
            4'd3:    r = f0_t'(1274374);
            4'd4:    r = f0_t'(1350153);
            4'd5:    r = f0_t'(1430441);
            4'd6:    r = f0_t'(1515500);
            4'd7:    r = f0_t'(1605612);
            4'd8:    r = f0_t'(1701085);
            4'd9:    r = f0_t'(1802240);
            4'd10:   r = f0_t'(1909404);
            4'd11:   r = f0_t'(2022946);
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/scale_note_quantizer_if.sv
// Request/result bundle between the pitch detector side (master) and the
// scale note quantizer (slave).
interface scale_note_quantizer_if
    import auto_tune_pkg::*;
#(
    parameter int NOTES  = DEF_NOTES,
    parameter int OCT_W  = DEF_OCT_W,
    parameter int FREQ_W = DEF_FREQ_W
);

    logic              start;
    logic [3:0]        note_name;
    logic [OCT_W-1:0]  note_octave;
    logic [1:0]        mode;
    logic [NOTES-1:0]  scale;

    logic              busy;
    logic              done;
    logic [3:0]        snapped_name;
    logic [OCT_W-1:0]  snapped_octave;
    logic [FREQ_W-1:0] freq_desired;
    logic              scale_empty;

    modport master (
        output start, note_name, note_octave, mode, scale,
        input  busy, done, snapped_name, snapped_octave, freq_desired, scale_empty
    );

    modport slave (
        input  start, note_name, note_octave, mode, scale,
        output busy, done, snapped_name, snapped_octave, freq_desired, scale_empty
    );

endinterface

// File: rtl/scale_note_quantizer_note_freq_rom.sv
// Registered note -> F0 lookup followed by the octave shift; the register
// loads only when 'load' is high and otherwise holds the last frequency.
module note_freq_rom
    import auto_tune_pkg::*;
#(
    parameter int OCT_W  = DEF_OCT_W,
    parameter int FREQ_W = DEF_FREQ_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [3:0]        note,
    input  logic [OCT_W-1:0]  octave,
    output logic [FREQ_W-1:0] freq
);

    logic [FREQ_W-1:0] f0;
    logic [FREQ_W-1:0] freq_d, freq_q;

    // Rescale the Q16 table to the output fraction width.
    if (FRAC_W >= F0_FRAC_W) begin : g_frac_up
        assign f0 = FREQ_W'(note_f0(note)) << (FRAC_W - F0_FRAC_W);
    end else begin : g_frac_dn
        assign f0 = FREQ_W'(note_f0(note)) >> (F0_FRAC_W - FRAC_W);
    end

    // Next frequency: shifted F0 on load, otherwise hold.
    always_comb begin
        freq_d = freq_q;
        if (load) begin
            freq_d = f0 << octave;
        end
    end

    // Frequency register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freq_q <= '0;
        end else begin
            freq_q <= freq_d;
        end
    end

    assign freq = freq_q;

endmodule

// File: rtl/scale_note_quantizer.sv
// Scale note quantizer: snaps a detected note/octave to the nearest allowed
// note of the scale mask, searching down, up or both ways one distance per
// cycle with wrap across octaves, then looks up the target frequency.
// Build option: define SNAP_CACHE_EN for a 1-entry request/result cache.
module scale_note_quantizer
    import auto_tune_pkg::*;
#(
    parameter int NOTES  = DEF_NOTES,
    parameter int OCT_W  = DEF_OCT_W,
    parameter int FREQ_W = DEF_FREQ_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input logic                  clk,
    input logic                  reset,
    scale_note_quantizer_if.slave bus
);

    localparam logic [3:0]       LAST_NOTE = 4'(NOTES - 1);
    localparam logic [OCT_W-1:0] MAX_OCT   = '1;
    localparam logic [OCT_W-1:0] OCT_ONE   = OCT_W'(1);

    typedef struct packed {
        logic [3:0]       note;
        logic [OCT_W-1:0] oct;
    } pitch_t;

    // Step one semitone up, wrapping into the next octave.
    function automatic pitch_t pitch_inc(input pitch_t p);
        pitch_t r;
        r = p;
        if (p.note == LAST_NOTE) begin
            r.note = '0;
            r.oct  = p.oct + OCT_ONE;
        end else begin
            r.note = p.note + 4'd1;
        end
        return r;
    endfunction

    // Step one semitone down, wrapping into the previous octave.
    function automatic pitch_t pitch_dec(input pitch_t p);
        pitch_t r;
        r = p;
        if (p.note == '0) begin
            r.note = LAST_NOTE;
            r.oct  = p.oct - OCT_ONE;
        end else begin
            r.note = p.note - 4'd1;
        end
        return r;
    endfunction

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [NOTES-1:0] scale_q, scale_d;
    pitch_t           dn_q, dn_d;          // downward candidate
    pitch_t           up_q, up_d;          // upward candidate
    logic             en_dn_q, en_dn_d;    // downward side still searching
    logic             en_up_q, en_up_d;    // upward side still searching
    pitch_t           res_q, res_d;        // search result feeding the ROM
    logic             res_empty_q, res_empty_d;
    pitch_t           snap_q, snap_d;      // published result
    logic             empty_q, empty_d;

    logic       [3:0] note_clamped;
    logic             hit_dn, hit_up;
    logic             cache_hit;

    assign note_clamped = (bus.note_name > LAST_NOTE) ? LAST_NOTE : bus.note_name;
    assign hit_dn       = en_dn_q && scale_q[dn_q.note];
    assign hit_up       = en_up_q && scale_q[up_q.note];

`ifdef SNAP_CACHE_EN
    typedef struct packed {
        logic [3:0]       note;
        logic [OCT_W-1:0] oct;
        logic [1:0]       mode;
        logic [NOTES-1:0] scale;
    } key_t;

    key_t key_q, key_d, req_key;
    logic valid_q, valid_d;

    // The published outputs always belong to key_q once valid, so a hit
    // only has to replay done.
    assign req_key   = {note_clamped, bus.note_octave, bus.mode, bus.scale};
    assign cache_hit = valid_q && (req_key == key_q);

    // Capture the key on a new search; mark it valid when its result lands.
    always_comb begin
        key_d   = key_q;
        valid_d = valid_q;
        if (state_q == ST_IDLE && bus.start && !cache_hit) begin
            key_d   = req_key;
            valid_d = 1'b0;
        end else if (state_q == ST_LOOKUP) begin
            valid_d = 1'b1;
        end
    end

    // Cache registers; reset invalidates the entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            key_q   <= key_d;
            valid_q <= valid_d;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // FSM next-state, search stepping and result publication.
    always_comb begin
        // NOTE: every _d gets its hold value first, so no branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        scale_d     = scale_q;
        dn_d        = dn_q;
        up_d        = up_q;
        en_dn_d     = en_dn_q;
        en_up_d     = en_up_q;
        res_d       = res_q;
        res_empty_d = res_empty_q;
        snap_d      = snap_q;
        empty_d     = empty_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                    if (cache_hit) begin
                        state_d = ST_HIT;
                    end else begin
                        state_d = ST_SEARCH;
                        scale_d = bus.scale;
                        dn_d    = {note_clamped, bus.note_octave};
                        up_d    = {note_clamped, bus.note_octave};
                        en_dn_d = (bus.mode != MODE_UP);
                        en_up_d = (bus.mode != MODE_DOWN);
                    end
                end
            end

            ST_SEARCH: begin
                if (scale_q == '0) begin
                    res_d       = dn_q;          // still the input note at d=0
                    res_empty_d = 1'b1;
                    state_d     = ST_LOOKUP;
                end else if (hit_dn) begin      // down wins ties
                    res_d       = dn_q;
                    res_empty_d = 1'b0;
                    state_d     = ST_LOOKUP;
                end else if (hit_up) begin
                    res_d       = up_q;
                    res_empty_d = 1'b0;
                    state_d     = ST_LOOKUP;
                end else begin
                    // A side that would leave the octave range stops; in a
                    // single-direction mode the idle side (still parked on the
                    // input note) takes over at distance 1.
                    if (en_dn_q) begin
                        if (dn_q == '0) begin
                            en_dn_d = 1'b0;
                            if (!en_up_q) begin
                                en_up_d = 1'b1;
                                up_d    = pitch_inc(up_q);
                            end
                        end else begin
                            dn_d = pitch_dec(dn_q);
                        end
                    end
                    if (en_up_q) begin
                        if (up_q.note == LAST_NOTE && up_q.oct == MAX_OCT) begin
                            en_up_d = 1'b0;
                            if (!en_dn_q) begin
                                en_dn_d = 1'b1;
                                dn_d    = pitch_dec(dn_q);
                            end
                        end else begin
                            up_d = pitch_inc(up_q);
                        end
                    end
                end
            end

            ST_LOOKUP: begin
                // The ROM loads on this same edge, so all outputs change with done.
                snap_d  = res_q;
                empty_d = res_empty_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_DONE;
            end

            ST_HIT: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; async reset abandons any request.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values, whatever the statement order.
        if (reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            scale_q     <= '0;
            dn_q        <= '0;
            up_q        <= '0;
            en_dn_q     <= 1'b0;
            en_up_q     <= 1'b0;
            res_q       <= '0;
            res_empty_q <= 1'b0;
            snap_q      <= '0;
            empty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            scale_q     <= scale_d;
            dn_q        <= dn_d;
            up_q        <= up_d;
            en_dn_q     <= en_dn_d;
            en_up_q     <= en_up_d;
            res_q       <= res_d;
            res_empty_q <= res_empty_d;
            snap_q      <= snap_d;
            empty_q     <= empty_d;
        end
    end

    note_freq_rom #(
        .OCT_W (OCT_W),
        .FREQ_W(FREQ_W),
        .FRAC_W(FRAC_W)
    ) u_rom (
        .clk   (clk),
        .reset (reset),
        .load  (state_q == ST_LOOKUP),
        .note  (res_q.note),
        .octave(res_q.oct),
        .freq  (bus.freq_desired)
    );

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.snapped_name   = snap_q.note;
    assign bus.snapped_octave = snap_q.oct;
    assign bus.scale_empty    = empty_q;

endmodule
